// File: rtl/vedic_seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// vedic_seq_mul_ctrl
//
// Computes an unsigned W x W product by time-multiplexing one external
// combinational CW x CW Vedic multiplier core over the (W/CW)^2 operand-slice
// pairs. Operands are latched on an accepted start, each slice pair is driven
// to the core for one cycle, and the shifted partial products are summed
// into a 2W-bit accumulator. The final sum is loaded into p together with a
// one-cycle done strobe.
//
// Handshake: start is a request that is accepted on a rising clk edge only
// when busy=0 (IDLE or DONE). While busy=1, start is ignored entirely.
// There is no queueing. done is a one-cycle strobe that marks a new p.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, accepted when busy=0
//   a, b       W-bit operands, sampled on the accepting edge
//   busy       high while partial products are being accumulated
//   done       one-cycle strobe, p holds a new result
//   p          2W-bit registered product, held until the next done
//   core_a/b   CW-bit operand slices to the external core (0 unless RUN)
//   core_p     2CW-bit combinational product from the external core
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module vedic_seq_mul_ctrl #(
   parameter int W  = 256,
   parameter int CW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic            busy,
   output logic            done,
   output logic [2*W-1:0]  p,
   output logic [CW-1:0]   core_a,
   output logic [CW-1:0]   core_b,
   input  logic [2*CW-1:0] core_p,
   output logic [1:0]      dbg_state
);

   localparam int N  = W / CW;
   localparam int NN = N * N;
   localparam int IW = (NN > 1) ? $clog2(NN) : 1;

   localparam logic [IW-1:0] N_L    = IW'(N);
   localparam logic [IW-1:0] LAST_L = IW'(NN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e         state_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] p_q;
   logic [IW-1:0]  idx_q;
   logic           busy_q;
   logic           done_q;

   logic [IW-1:0]  i_sel;
   logic [IW-1:0]  j_sel;
   int unsigned    shamt;
   logic [2*W-1:0] pp_ext;
   logic [2*W-1:0] pp_shift;
   logic [2*W-1:0] acc_d;
   logic           last_pp;

   // Slice selection and partial-product alignment. The row/column of the
   // current pair come from idx; the partial product lands at CW*(i+j).
   always_comb begin
      i_sel    = idx_q / N_L;
      j_sel    = idx_q % N_L;
      shamt    = CW * (int'(i_sel) + int'(j_sel));
      pp_ext   = '0;
      pp_ext[2*CW-1:0] = core_p;
      pp_shift = pp_ext << shamt;
      acc_d    = acc_q + pp_shift;
      last_pp  = (idx_q == LAST_L);
   end

   // Core operands are forced to zero outside RUN so the shared core sees a
   // quiet input whenever this controller is not using it.
   always_comb begin
      core_a = '0;
      core_b = '0;
      if (state_q == S_RUN) begin
         core_a = a_q[CW*i_sel +: CW];
         core_b = b_q[CW*j_sel +: CW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end

            S_RUN: begin
               acc_q <= acc_d;
               if (last_pp) begin
                  // The last partial product goes straight into p so the
                  // result is valid in the same cycle as done.
                  p_q     <= acc_d;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end

            S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign p         = p_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vedic_seq_mul_ctrl
//
// Drives the sequential multiplier controller against a behavioural 64x64
// reference core. Directed vectors come from a table; back-to-back, busy
// start pulses, mid-run reset and a random sweep are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_vedic_seq_mul_ctrl;

   localparam int W  = 256;
   localparam int CW = 64;
   localparam int NN = (W / CW) * (W / CW);

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  p;
   logic [CW-1:0]   core_a;
   logic [CW-1:0]   core_b;
   logic [2*CW-1:0] core_p;
   logic [1:0]      dbg_state;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   // clock / reset block
   always #5 clk = ~clk;

   // behavioural reference core
   assign core_p = {{CW{1'b0}}, core_a} * {{CW{1'b0}}, core_b};

   vedic_seq_mul_ctrl #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .p         (p),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_p    (core_p),
      .dbg_state (dbg_state)
   );

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
      string          name;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [2*W-1:0] got,
                      input logic [2*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom();
      return r;
   endfunction

   // Core inputs must be quiet whenever the controller is not busy.
   always @(negedge clk) begin
      if (mon_en && !busy) chk("core_idle_zero", {core_a, core_b}, '0);
   end

   // Presents start at the current negedge and follows the operation through
   // to the done cycle; returns at the negedge of the done cycle with start=0.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2*W-1:0] exp, input bit junk,
                         input string name);
      int busy_cnt;
      bit early_done;
      busy_cnt   = 0;
      early_done = 1'b0;
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < NN; c++) begin
         if (busy) busy_cnt++;
         if (done) early_done = 1'b1;
         if (junk && c < 12 && (c % 3) == 0) begin
            start = 1'b1;
            a     = rand_w();
            b     = rand_w();
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, "_busy_cycles"}, 512'(busy_cnt), 512'(NN));
      chk({name, "_early_done"}, 512'(early_done), 512'd0);
      chk({name, "_done"}, 512'(done), 512'd1);
      chk({name, "_busy_low"}, 512'(busy), 512'd0);
      chk({name, "_p"}, p, exp);
   endtask

   initial begin
      logic [2*W-1:0] all_ones_exp;
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      int             done_seen;

      all_ones_exp = '1;
      all_ones_exp = all_ones_exp - (512'd1 << 257) + 512'd2;

      vecs[0] = '{a: 256'd57,         b: 256'd9495,
                  exp: 512'd541215,              name: "v57x9495"};
      vecs[1] = '{a: 256'd5711,       b: 256'd5006500000,
                  exp: 512'd28592121500000,      name: "v5711"};
      vecs[2] = '{a: 256'd1 << 64,    b: 256'd1 << 192,
                  exp: 512'd1 << 256,            name: "vpow2"};
      vecs[3] = '{a: '1,              b: '1,
                  exp: all_ones_exp,             name: "vones"};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 512'(busy), 512'd0);
      chk("rst_done", 512'(done), 512'd0);
      chk("rst_p", p, '0);
      chk("rst_core", {core_a, core_b}, '0);
      mon_en = 1'b1;
      @(negedge clk);

      // directed table
      for (int v = 0; v < 4; v++) begin
         run_op(vecs[v].a, vecs[v].b, vecs[v].exp, 1'b0, vecs[v].name);
         @(negedge clk);
         chk({vecs[v].name, "_hold_done"}, 512'(done), 512'd0);
         chk({vecs[v].name, "_hold_p"}, p, vecs[v].exp);
         repeat (2) @(negedge clk);
         chk({vecs[v].name, "_hold_p2"}, p, vecs[v].exp);
      end

      // back-to-back with ignored start pulses while busy
      run_op(256'd5711, 256'd5006500000, 512'd28592121500000, 1'b1, "b2b_first");
      run_op(256'd122457, 256'd9495, 512'd1162729215, 1'b1, "b2b_second");
      @(negedge clk);
      chk("b2b_hold_p", p, 512'd1162729215);

      // reset in RUN cycle 8
      start = 1'b1;
      a     = 256'd57;
      b     = 256'd9495;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_busy_before", 512'(busy), 512'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 512'(busy), 512'd0);
      chk("abort_done", 512'(done), 512'd0);
      chk("abort_p", p, '0);
      done_seen = 0;
      for (int c = 0; c < 24; c++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      chk("abort_no_done", 512'(done_seen), 512'd0);
      run_op(256'd57568, 256'd459394, 512'd26446393792, 1'b0, "after_abort");
      @(negedge clk);

      // random sweep
      for (int r = 0; r < 200; r++) begin
         ra = rand_w();
         rb = rand_w();
         run_op(ra, rb, {{W{1'b0}}, ra} * {{W{1'b0}}, rb}, 1'b0, "rand");
      end
      @(negedge clk);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
